pwm_multi_ctrl: RTL and testbench

- Parametrised successor to the single-channel PWM path: parses PWM parameter frames from the user UDP AXIS stream and drives NUM_CH independent PWM outputs.
- Adds over the previous generation: configurable counter width and channel count, edge/center-aligned mode, output polarity, frame-error detection, and glitch-free shadow update at period boundary.
- Sits between the UDP receive path and the board PWM pins.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_channel.sv | 124 ++++++++++++
 rtl/pwm_multi_ctrl.sv | 140 ++++++++++++++
 tb/tb_pwm_multi_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller: frame field
// positions, mode encodings, parser states and the per-channel flag bundle.
package pwm_pkg;

  localparam int CH_MSB      = 31;
  localparam int CH_LSB      = 24;
  localparam int EN_BIT      = 23;
  localparam int MODE_BIT    = 22;
  localparam int POL_BIT     = 21;
  localparam int FRAME_WORDS = 3;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic [1:0] {IDLE, W1, W2, SKIP} parse_state_e;

  typedef struct packed {
    logic en;
    logic mode;
    logic pol;
  } pwm_flags_t;

  function automatic pwm_flags_t w0_flags(input logic [31:0] w);
    pwm_flags_t f;
    f.en   = w[EN_BIT];
    f.mode = w[MODE_BIT];
    f.pol  = w[POL_BIT];
    return f;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active parameter sets, edge or center counter,
// boundary-gated shadow transfer and a registered, polarity-adjusted pin.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  pwm_flags_t       wr_flags,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_hlevel,
  input  logic             sync,
  output logic             pin
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_flags_t       pend_q, pend_d, act_q, act_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_hlevel_q, pend_hlevel_d;
  logic [CNT_W-1:0] act_period_q, act_period_d, act_hlevel_q, act_hlevel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d, dir_dn_q, dir_dn_d, pin_q, pin_d;
  logic             run, boundary, take_wr, xfer;

  always_comb begin
    run      = act_q.en && (act_period_q != '0);
    boundary = act_q.en && ((act_q.mode == MODE_CENTER) ? ((cnt_q == '0) && dir_dn_q)
                                                         : (cnt_q == act_period_q));
    // a commit landing on the sync cycle applies at that sync
    take_wr  = wr && sync;
    xfer     = take_wr || (pend_vld_q && (!act_q.en || boundary || sync));

    pend_d        = pend_q;
    pend_period_d = pend_period_q;
    pend_hlevel_d = pend_hlevel_q;
    pend_vld_d    = pend_vld_q && !xfer;
    if (wr) begin
      pend_d        = wr_flags;
      pend_period_d = wr_period;
      pend_hlevel_d = wr_hlevel;
      pend_vld_d    = !take_wr;
    end

    act_d        = act_q;
    act_period_d = act_period_q;
    act_hlevel_d = act_hlevel_q;
    if (take_wr) begin
      act_d        = wr_flags;
      act_period_d = wr_period;
      act_hlevel_d = wr_hlevel;
    end else if (xfer) begin
      act_d        = pend_q;
      act_period_d = pend_period_q;
      act_hlevel_d = pend_hlevel_q;
    end

    // dir_dn_q at cnt==0 marks the start of a center period (the boundary)
    cnt_d    = cnt_q;
    dir_dn_d = 1'b1;
    if (act_q.mode == MODE_CENTER) begin
      dir_dn_d = dir_dn_q;
      if (dir_dn_q) begin
        if (cnt_q == '0) begin
          cnt_d    = ONE;
          dir_dn_d = 1'b0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end else if (cnt_q >= act_period_q) begin
        cnt_d    = cnt_q - ONE;
        dir_dn_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = (cnt_q >= act_period_q) ? '0 : cnt_q + ONE;
    end

    if (sync) begin
      cnt_d    = '0;
      dir_dn_d = 1'b0;
    end else if (xfer && !act_q.en) begin
      cnt_d    = '0;
      dir_dn_d = 1'b1;
    end
    if (!act_d.en || (act_period_d == '0)) begin
      cnt_d    = '0;
      dir_dn_d = 1'b1;
    end

    pin_d = run ? ((cnt_q < act_hlevel_q) ^ act_q.pol) : act_q.pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      pend_period_q <= '0;
      pend_hlevel_q <= '0;
      pend_vld_q    <= 1'b0;
      act_q         <= '0;
      act_period_q  <= '0;
      act_hlevel_q  <= '0;
      cnt_q         <= '0;
      dir_dn_q      <= 1'b1;
      pin_q         <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pend_period_q <= pend_period_d;
      pend_hlevel_q <= pend_hlevel_d;
      pend_vld_q    <= pend_vld_d;
      act_q         <= act_d;
      act_period_q  <= act_period_d;
      act_hlevel_q  <= act_hlevel_d;
      cnt_q         <= cnt_d;
      dir_dn_q      <= dir_dn_d;
      pin_q         <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Frame parser, error counter and NUM_CH pwm_channel instances.
// Define PWM_SYNC_EN to add the pwm_sync phase-alignment input.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int PWM_PARAM_TYPE = 0,
  parameter int NUM_CH         = 8,
  parameter int CNT_W          = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       rx_axis_udp_tdata,
  input  logic              rx_axis_udp_tvalid,
  input  logic              rx_axis_udp_tlast,
  input  logic              rx_axis_udp_tuser,
`ifdef PWM_SYNC_EN
  input  logic              pwm_sync,
`endif
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [15:0]       cfg_err_cnt,
  output logic [NUM_CH-1:0] pwm
);

  localparam logic TYPE_BIT = PWM_PARAM_TYPE[0];

  parse_state_e     state_q, state_d;
  logic [7:0]       ch_q, ch_d;
  pwm_flags_t       flags_q, flags_d;
  logic [CNT_W-1:0] period_q, period_d, hlevel_q, hlevel_d;
  logic             commit_q, commit_d, err_q, err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             sync_p;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    flags_d  = flags_q;
    period_d = period_q;
    hlevel_d = hlevel_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (rx_axis_udp_tvalid) begin
      case (state_q)
        IDLE: begin
          if (rx_axis_udp_tuser == TYPE_BIT) begin
            ch_d    = rx_axis_udp_tdata[CH_MSB:CH_LSB];
            flags_d = w0_flags(rx_axis_udp_tdata);
            if (rx_axis_udp_tlast) err_d   = 1'b1;
            else                   state_d = W1;
          end else if (!rx_axis_udp_tlast) begin
            state_d = SKIP;
          end
        end
        W1: begin
          period_d = rx_axis_udp_tdata[CNT_W-1:0];
          if (rx_axis_udp_tlast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = W2;
          end
        end
        W2: begin
          hlevel_d = rx_axis_udp_tdata[CNT_W-1:0];
          state_d  = IDLE;
          if (!rx_axis_udp_tlast) begin
            err_d   = 1'b1;
            state_d = SKIP;
          end else if ({1'b0, ch_q} >= 9'(NUM_CH)) begin
            err_d = 1'b1;
          end else begin
            commit_d = 1'b1;
          end
        end
        SKIP:    if (rx_axis_udp_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    err_cnt_d = (err_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      flags_q   <= '0;
      period_q  <= '0;
      hlevel_q  <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      flags_q   <= flags_d;
      period_q  <= period_d;
      hlevel_q  <= hlevel_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef PWM_SYNC_EN
  logic sync_in_q, sync_p_q, sync_p_d;
  assign sync_p_d = pwm_sync && !sync_in_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_in_q <= 1'b0;
      sync_p_q  <= 1'b0;
    end else begin
      sync_in_q <= pwm_sync;
      sync_p_q  <= sync_p_d;
    end
  end
  assign sync_p = sync_p_q;
`else
  assign sync_p = 1'b0;
`endif

  // channel regs load from the committed frame regs while commit_q is high
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (commit_q && (ch_q == 8'(i))),
      .wr_flags  (flags_q),
      .wr_period (period_q),
      .wr_hlevel (hlevel_q),
      .sync      (sync_p),
      .pin       (pwm[i])
    );
  end

  assign cfg_done    = commit_q;
  assign cfg_err     = err_q;
  assign cfg_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl; pin waveforms are captured per cycle
// into hist[] and compared against hand-derived patterns.
module tb_pwm_multi_ctrl;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [31:0]       tdata = '0;
  logic              tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic              cfg_done, cfg_err;
  logic [15:0]       cfg_err_cnt;
  logic [NUM_CH-1:0] pwm;
`ifdef PWM_SYNC_EN
  logic              pwm_sync = 1'b0;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  logic [NUM_CH-1:0] hist [0:4095];

  pwm_multi_ctrl #(.PWM_PARAM_TYPE(0), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .rx_axis_udp_tuser  (tuser),
`ifdef PWM_SYNC_EN
    .pwm_sync           (pwm_sync),
`endif
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .cfg_err_cnt        (cfg_err_cnt),
    .pwm                (pwm)
  );

  always #5 clk = ~clk;

  // hist[c] holds the pwm value seen at the negedge where cyc read c
  always @(posedge clk) begin
    if (cyc < 4096) hist[cyc] <= pwm;
    cyc <= cyc + 1;
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic user);
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tlast = last; tuser = user;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  function automatic logic [31:0] w0(input logic [7:0] ch, input logic en,
                                     input logic mode, input logic pol);
    return {ch, en, mode, pol, 21'h0};
  endfunction

  // returns at the negedge where cfg_done of this frame is visible
  task automatic send_frame(input logic [7:0] ch, input logic en, input logic mode,
                            input logic pol, input logic [31:0] per, input logic [31:0] hl);
    send_word(w0(ch, en, mode, pol), 1'b0, 1'b0);
    send_word(per, 1'b0, 1'b0);
    send_word(hl, 1'b1, 1'b0);
    idle_bus();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cfg_done !== 1'b0) begin n_errs++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
    n_checks++; if (cfg_err !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    n_checks++; if (cfg_err_cnt !== 16'd0) begin n_errs++; $display("FAIL reset_errcnt: got %0d expected 0", cfg_err_cnt); end
    n_checks++; if (pwm !== '0) begin n_errs++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (pwm !== '0) begin n_errs++; $display("FAIL post_reset_pwm: got %b expected 0", pwm); end
  endtask

  task automatic test_edge();
    int base;
    logic [NUM_CH-1:0] e;
    send_frame(8'd2, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    n_checks++; if (cfg_done !== 1'b1) begin n_errs++; $display("FAIL edge_done: got %b expected 1", cfg_done); end
    base = cyc;
    @(negedge clk);
    n_checks++; if (cfg_done !== 1'b0) begin n_errs++; $display("FAIL edge_done_pulse: got %b expected 0", cfg_done); end
    repeat (25) @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      e = '0;
      e[2] = (k >= 3) && (((k - 3) % 10) < 3);
      n_checks++;
      if (hist[base+k] !== e) begin n_errs++; $display("FAIL edge_k%0d: got %b expected %b", k, hist[base+k], e); end
    end
  endtask

  task automatic test_mid_update();
    int base;
    logic e;
    send_frame(8'd0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    base = cyc;
    repeat (4) @(negedge clk);
    send_frame(8'd0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd7);
    n_checks++; if (cfg_done !== 1'b1) begin n_errs++; $display("FAIL mid_done: got %b expected 1", cfg_done); end
    repeat (36) @(negedge clk);
    for (int k = 0; k <= 40; k++) begin
      if (k < 13) e = (k >= 3) && (k <= 5);
      else        e = ((k - 13) % 10) < 7;
      n_checks++;
      if (hist[base+k][0] !== e) begin n_errs++; $display("FAIL mid_k%0d: got %b expected %b", k, hist[base+k][0], e); end
    end
  endtask

  task automatic test_center();
    int base;
    logic e;
    send_frame(8'd1, 1'b1, 1'b1, 1'b1, 32'd4, 32'd2);
    base = cyc;
    repeat (32) @(negedge clk);
    for (int k = 0; k <= 30; k++) begin
      if (k < 5)       e = 1'b0;
      else if (k < 10) e = 1'b1;
      else             e = ((k - 10) % 8) >= 3;
      n_checks++;
      if (hist[base+k][1] !== e) begin n_errs++; $display("FAIL center_k%0d: got %b expected %b", k, hist[base+k][1], e); end
    end
  endtask

  task automatic test_frame_err();
    // tlast on W1
    send_word(w0(8'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    send_word(32'd9, 1'b1, 1'b0);
    idle_bus();
    n_checks++; if (cfg_err !== 1'b1) begin n_errs++; $display("FAIL w1_last_err: got %b expected 1", cfg_err); end
    n_checks++; if (cfg_err_cnt !== 16'd1) begin n_errs++; $display("FAIL w1_last_cnt: got %0d expected 1", cfg_err_cnt); end
    n_checks++; if (cfg_done !== 1'b0) begin n_errs++; $display("FAIL w1_last_done: got %b expected 0", cfg_done); end
    @(negedge clk);
    n_checks++; if (cfg_err !== 1'b0) begin n_errs++; $display("FAIL w1_last_pulse: got %b expected 0", cfg_err); end
    // out-of-range channel
    send_frame(8'd200, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    n_checks++; if (cfg_err !== 1'b1) begin n_errs++; $display("FAIL ch200_err: got %b expected 1", cfg_err); end
    n_checks++; if (cfg_err_cnt !== 16'd2) begin n_errs++; $display("FAIL ch200_cnt: got %0d expected 2", cfg_err_cnt); end
    n_checks++; if (cfg_done !== 1'b0) begin n_errs++; $display("FAIL ch200_done: got %b expected 0", cfg_done); end
    // foreign frame type: silently skipped
    send_word(w0(8'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);
    send_word(32'd9, 1'b0, 1'b1);
    send_word(32'd3, 1'b1, 1'b1);
    idle_bus();
    n_checks++; if ({cfg_done, cfg_err} !== 2'b00) begin n_errs++; $display("FAIL tuser_flags: got %b expected 00", {cfg_done, cfg_err}); end
    n_checks++; if (cfg_err_cnt !== 16'd2) begin n_errs++; $display("FAIL tuser_cnt: got %0d expected 2", cfg_err_cnt); end
    // missing tlast on W2, then the tail word is skipped
    send_word(w0(8'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    send_word(32'd9, 1'b0, 1'b0);
    send_word(32'd3, 1'b0, 1'b0);
    send_word(32'd5, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b1) begin n_errs++; $display("FAIL w2_nolast_err: got %b expected 1", cfg_err); end
    n_checks++; if (cfg_err_cnt !== 16'd3) begin n_errs++; $display("FAIL w2_nolast_cnt: got %0d expected 3", cfg_err_cnt); end
    idle_bus();
    n_checks++; if ({cfg_done, cfg_err} !== 2'b00) begin n_errs++; $display("FAIL skip_tail: got %b expected 00", {cfg_done, cfg_err}); end
    repeat (6) @(negedge clk);
    n_checks++; if (pwm[3] !== 1'b0) begin n_errs++; $display("FAIL ch3_untouched: got %b expected 0", pwm[3]); end
    // parser recovers for the next good frame
    send_frame(8'd3, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
    n_checks++; if (cfg_done !== 1'b1) begin n_errs++; $display("FAIL recover_done: got %b expected 1", cfg_done); end
    n_checks++; if (cfg_err_cnt !== 16'd3) begin n_errs++; $display("FAIL recover_cnt: got %0d expected 3", cfg_err_cnt); end
  endtask

  task automatic test_boundaries();
    send_frame(8'd4, 1'b1, 1'b0, 1'b0, 32'd9,  32'd0);
    send_frame(8'd5, 1'b1, 1'b0, 1'b0, 32'd9,  32'd12);
    send_frame(8'd6, 1'b1, 1'b0, 1'b1, 32'd0,  32'd5);
    send_frame(8'd7, 1'b0, 1'b0, 1'b1, 32'd9,  32'd3);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (pwm[7:4] !== 4'b1110) begin n_errs++; $display("FAIL bound_k%0d: got %b expected 1110", k, pwm[7:4]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_word(w0(8'd2, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    send_word(32'd9, 1'b0, 1'b0);
    @(negedge clk);
    tdata = 32'd3; tlast = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (pwm !== '0) begin n_errs++; $display("FAIL rst_mid_pwm: got %b expected 0", pwm); end
    n_checks++; if (cfg_err_cnt !== 16'd0) begin n_errs++; $display("FAIL rst_mid_cnt: got %0d expected 0", cfg_err_cnt); end
    tvalid = 1'b0; tlast = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({cfg_done, pwm} !== '0) begin n_errs++; $display("FAIL rst_mid_k%0d: got done=%b pwm=%b expected 0", k, cfg_done, pwm); end
    end
  endtask

`ifdef PWM_SYNC_EN
  task automatic test_sync();
    int base;
    logic e;
    send_frame(8'd0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    repeat (3) @(negedge clk);
    send_frame(8'd1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    repeat (2) @(negedge clk);
    pwm_sync = 1'b1;
    base = cyc;
    @(negedge clk);
    pwm_sync = 1'b0;
    repeat (24) @(negedge clk);
    for (int k = 3; k < 23; k++) begin
      e = ((k - 3) % 10) < 3;
      n_checks++;
      if (hist[base+k][1:0] !== {e, e}) begin n_errs++; $display("FAIL sync_k%0d: got %b expected %b", k, hist[base+k][1:0], {e, e}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_edge();
    test_mid_update();
    test_center();
    test_frame_err();
    test_boundaries();
    test_reset_mid_frame();
`ifdef PWM_SYNC_EN
    test_sync();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
